// File: rtl/ram512x9_mult_pkg.sv
// rtl/ram512x9_mult_pkg.sv - shared widths and constants for the RAM/multiplier core
package ram512x9_mult_pkg;

  localparam int DATA_WIDTH = 9;
  localparam int ADDR_WIDTH = 9;
  localparam int MA_A_WIDTH = 5;
  localparam int MB_WIDTH   = 10;

  localparam int MA_P_WIDTH = MA_A_WIDTH + DATA_WIDTH;
  localparam int MB_P_WIDTH = 2 * MB_WIDTH;

  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;

  localparam int DISTEU_RESULT_NUMBER = 31;

  typedef logic [DATA_WIDTH-1:0] ram_word_t;
  typedef logic [ADDR_WIDTH-1:0] ram_addr_t;

endpackage

// File: rtl/ram512x9_mult_core_pipe_mult.sv
// rtl/ram512x9_mult_core_pipe_mult.sv - registered multiplier, selectable signed/unsigned operands
module pipe_mult #(
  parameter int A_W = 5,
  parameter int B_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_signed,
  input  logic             i_ce,
  input  logic [A_W-1:0]   i_a,
  input  logic [B_W-1:0]   i_b,
  output logic [A_W+B_W-1:0] o_p
);

  localparam int P_W = A_W + B_W;

  logic           w_sa;
  logic           w_sb;
  logic [P_W-1:0] w_a_ext;
  logic [P_W-1:0] w_b_ext;
  logic [P_W-1:0] w_prod;
  logic [P_W-1:0] r_p;

  // Extend both operands to the full product width (sign or zero), so the low
  // P_W bits of the product are exact in either mode.
  assign w_sa    = i_signed & i_a[A_W-1];
  assign w_sb    = i_signed & i_b[B_W-1];
  assign w_a_ext = {{B_W{w_sa}}, i_a};
  assign w_b_ext = {{A_W{w_sb}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Product register: cleared by reset, held while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (i_ce) begin
      r_p <= w_prod;
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/ram512x9_mult_core.sv
// rtl/ram512x9_mult_core.sv - 512x9 dual-port RAM plus two registered multipliers; RAM_WRITE_FIRST_EN selects write-first read bypass
module ram512x9_mult_core
  import ram512x9_mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ram_clr,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_ce,
  input  logic [MA_A_WIDTH-1:0] i_ma_a,
  input  logic [DATA_WIDTH-1:0] i_ma_b,
  output logic [MA_P_WIDTH-1:0] o_ma_p,
  input  logic [MB_WIDTH-1:0]   i_mb_a,
  input  logic [MB_WIDTH-1:0]   i_mb_b,
  output logic [MB_P_WIDTH-1:0] o_mb_p
);

  ram_word_t r_mem [RAM_DEPTH];
  ram_word_t r_rd_data;
  ram_word_t w_rd_next;
  logic      w_wr_go;

  // A write landing while the read register is being cleared is dropped.
  assign w_wr_go = i_wr_en & ~i_ram_clr;

`ifdef RAM_WRITE_FIRST_EN
  assign w_rd_next = (w_wr_go && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
`else
  assign w_rd_next = r_mem[i_rd_addr];
`endif

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_go) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read-data register: read every cycle, ram_clr forces zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_ram_clr) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_next;
    end
  end

  assign o_rd_data = r_rd_data;

  pipe_mult #(
    .A_W (MA_A_WIDTH),
    .B_W (DATA_WIDTH)
  ) u_mult_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_signed (1'b0),
    .i_ce     (i_ce),
    .i_a      (i_ma_a),
    .i_b      (i_ma_b),
    .o_p      (o_ma_p)
  );

  pipe_mult #(
    .A_W (MB_WIDTH),
    .B_W (MB_WIDTH)
  ) u_mult_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_signed (1'b1),
    .i_ce     (i_ce),
    .i_a      (i_mb_a),
    .i_b      (i_mb_b),
    .o_p      (o_mb_p)
  );

endmodule

// File: tb/tb_ram512x9_mult_core.sv
// tb/tb_ram512x9_mult_core.sv - directed self-checking bench for ram512x9_mult_core
module tb_ram512x9_mult_core;

  logic        clk;
  logic        rst_n;
  logic        ram_clr;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [8:0]  wr_data;
  logic [8:0]  rd_addr;
  logic [8:0]  rd_data;
  logic        ce;
  logic [4:0]  ma_a;
  logic [8:0]  ma_b;
  logic [13:0] ma_p;
  logic [9:0]  mb_a;
  logic [9:0]  mb_b;
  logic [19:0] mb_p;

  int checks;
  int failures;

  typedef struct {
    logic [4:0]  ma_a;
    logic [8:0]  ma_b;
    logic [9:0]  mb_a;
    logic [9:0]  mb_b;
    logic [13:0] exp_ma;
    logic [19:0] exp_mb;
  } mult_vec_t;

  mult_vec_t vecs [5];

  ram512x9_mult_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ram_clr (ram_clr),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data),
    .i_ce      (ce),
    .i_ma_a    (ma_a),
    .i_ma_b    (ma_b),
    .o_ma_p    (ma_p),
    .i_mb_a    (mb_a),
    .i_mb_b    (mb_b),
    .o_mb_p    (mb_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // (-3)*5=-15, (-512)*(-512)=262144, 511*(-512)=-261632, (-1)*(-1)=1, 0*(-512)=0
    vecs[0] = '{5'd31, 9'd511, 10'h3FD, 10'd5,   14'd15841, 20'hFFFF1};
    vecs[1] = '{5'd31, 9'd0,   10'h200, 10'h200, 14'd0,     20'h40000};
    vecs[2] = '{5'd5,  9'd9,   10'h1FF, 10'h200, 14'd45,    20'hC0200};
    vecs[3] = '{5'd17, 9'd300, 10'h3FF, 10'h3FF, 14'd5100,  20'h00001};
    vecs[4] = '{5'd1,  9'd1,   10'h000, 10'h200, 14'd1,     20'h00000};

    rst_n   = 1'b0;
    ram_clr = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    ce      = 1'b1;
    ma_a    = 5'd7;
    ma_b    = 9'd7;
    mb_a    = 10'd7;
    mb_b    = 10'd7;
    repeat (3) tick();
    check("reset_rd_data", 20'(rd_data), 20'h0);
    check("reset_ma_p", 20'(ma_p), 20'h0);
    check("reset_mb_p", mb_p, 20'h0);
    rst_n = 1'b1;

    // Write-then-read at both address extremes
    wr_en = 1'b1; wr_addr = 9'd0;   wr_data = 9'h1A5; tick();
    wr_addr = 9'd511; wr_data = 9'h003; tick();
    wr_en = 1'b0; rd_addr = 9'd511; tick();
    check("rd_addr511", 20'(rd_data), 20'h003);
    rd_addr = 9'd0; tick();
    check("rd_addr0", 20'(rd_data), 20'h1A5);

    // Read-during-write on the same address
    wr_en = 1'b1; wr_addr = 9'd7; wr_data = 9'h010; tick();
    wr_data = 9'h0FF; rd_addr = 9'd7; tick();
`ifdef RAM_WRITE_FIRST_EN
    check("rdw_same_cycle", 20'(rd_data), 20'h0FF);
`else
    check("rdw_same_cycle", 20'(rd_data), 20'h010);
`endif
    wr_en = 1'b0; tick();
    check("rdw_next_cycle", 20'(rd_data), 20'h0FF);

    // ram_clr zeroes the read register and blocks a concurrent write
    rd_addr = 9'd0; ram_clr = 1'b1; wr_en = 1'b1; wr_addr = 9'd0; wr_data = 9'h055; tick();
    check("ram_clr_zero", 20'(rd_data), 20'h0);
    ram_clr = 1'b0; wr_en = 1'b0; tick();
    check("ram_clr_survive", 20'(rd_data), 20'h1A5);

    // Multiplier vector table, ce held high
    for (int i = 0; i < 5; i++) begin
      ma_a = vecs[i].ma_a;
      ma_b = vecs[i].ma_b;
      mb_a = vecs[i].mb_a;
      mb_b = vecs[i].mb_b;
      tick();
      check($sformatf("ma_vec%0d", i), 20'(ma_p), 20'(vecs[i].exp_ma));
      check($sformatf("mb_vec%0d", i), mb_p, vecs[i].exp_mb);
    end

    // Clock-enable hold for three cycles
    ma_a = 5'd31; ma_b = 9'd511; mb_a = 10'h3FD; mb_b = 10'd5; tick();
    ce = 1'b0; ma_a = 5'd2; ma_b = 9'd3; mb_a = 10'd2; mb_b = 10'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ce_hold_ma%0d", i), 20'(ma_p), 20'd15841);
      check($sformatf("ce_hold_mb%0d", i), mb_p, 20'hFFFF1);
    end
    ce = 1'b1; tick();
    check("ce_resume_ma", 20'(ma_p), 20'd6);
    check("ce_resume_mb", mb_p, 20'd4);

    // Asynchronous reset between clock edges
    rd_addr = 9'd0; tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_rd", 20'(rd_data), 20'h0);
    check("async_rst_ma", 20'(ma_p), 20'h0);
    check("async_rst_mb", mb_p, 20'h0);
    tick();
    check("rst_held_ma", 20'(ma_p), 20'h0);
    #2 rst_n = 1'b1;
    ma_a = 5'd10; ma_b = 9'd10; mb_a = 10'h3FE; mb_b = 10'd3;
    #1;
    check("post_rel_ma_before_edge", 20'(ma_p), 20'h0);
    tick();
    check("post_rel_ma", 20'(ma_p), 20'd100);
    check("post_rel_mb", mb_p, 20'hFFFFA);
    check("post_rel_rd_mem_kept", 20'(rd_data), 20'h1A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
